// File: rtl/c_constants.sv
// Shared constants and small helpers used by the router flag blocks.
package c_constants;

  // VC reduction codes.
  localparam int REDUCE_FIRST = 32'sd0;
  localparam int REDUCE_OR    = 32'sd1;
  localparam int REDUCE_AND   = 32'sd2;

  // True when exactly one bit of the (zero-extended) vector is set.
  function automatic logic is_onehot(input logic [63:0] vec);
    return ($countones(vec) == 32'sd1);
  endfunction

endpackage

// File: rtl/c_select_1ofn.sv
// One-of-N selector: ORs together the data slices whose select bit is set.
// With a one-hot select this is a plain mux.
module c_select_1ofn #(
  parameter int num_ports = 2,
  parameter int width     = 1
) (
  input  logic [num_ports-1:0]       select,
  input  logic [num_ports*width-1:0] data_in,
  output logic [width-1:0]           data_out
);

  // AND-OR mux over all candidate slices.
  always_comb begin
    data_out = '0;
    for (int i = 0; i < num_ports; i++) begin
      data_out = data_out | (data_in[i*width +: width] & {width{select[i]}});
    end
  end

endmodule

// File: rtl/rtr_flags_reduce.sv
// Per-bit reduction of the flags of all VCs belonging to one packet class.
// Input layout is VC-major: vc_flags[vc*width + bit].
module rtr_flags_reduce
  import c_constants::*;
#(
  parameter int num_vcs_per_class = 1,
  parameter int width             = 1,
  parameter int reduce_mode       = REDUCE_OR
) (
  input  logic [num_vcs_per_class*width-1:0] vc_flags,
  output logic [width-1:0]                   reduced
);

  if (!((reduce_mode == REDUCE_FIRST) || (reduce_mode == REDUCE_OR) ||
        (reduce_mode == REDUCE_AND))) begin : g_bad_reduce_mode
    $error("rtr_flags_reduce: unsupported reduce_mode %0d", reduce_mode);
  end

  logic [width-1:0] or_s;
  logic [width-1:0] and_s;

  // OR and AND across VCs, then pick the configured result.
  always_comb begin
    or_s  = '0;
    and_s = '1;
    for (int v = 0; v < num_vcs_per_class; v++) begin
      or_s  = or_s  | vc_flags[v*width +: width];
      and_s = and_s & vc_flags[v*width +: width];
    end
    case (reduce_mode)
      REDUCE_FIRST: reduced = vc_flags[width-1:0];
      REDUCE_OR:    reduced = or_s;
      REDUCE_AND:   reduced = and_s;
      default:      reduced = '0;
    endcase
  end

endmodule

// File: rtl/rtr_flags_mux_pipe.sv
// Router per-VC flag store with a two-stage lookup pipeline.
// S1 captures the selected port's flag slice plus the class selects;
// S2 applies class selection and VC reduction. Flag layout is
// port-major, then message class, resource class, VC, bit.
module rtr_flags_mux_pipe
  import c_constants::*;
#(
  parameter int num_message_classes  = 2,
  parameter int num_resource_classes = 2,
  parameter int num_ports            = 5,
  parameter int num_vcs_per_class    = 1,
  parameter int width                = 1,
  parameter int reduce_mode          = REDUCE_OR
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic [num_ports*num_message_classes*num_resource_classes*num_vcs_per_class*width-1:0] flags_set,
  input  logic [num_ports*num_message_classes*num_resource_classes*num_vcs_per_class*width-1:0] flags_clr,
  input  logic                            req_valid,
  output logic                            req_ready,
  input  logic [num_message_classes-1:0]  req_mc,
  input  logic [num_ports-1:0]            req_op,
  input  logic [num_resource_classes-1:0] req_orc,
  output logic                            resp_valid,
  input  logic                            resp_ready,
  output logic [width-1:0]                resp_flags,
  output logic                            resp_err,
  output logic [num_ports*num_message_classes*num_resource_classes*num_vcs_per_class*width-1:0] flags_q
);

  localparam int rc_slice_w   = num_vcs_per_class * width;
  localparam int mc_slice_w   = num_resource_classes * rc_slice_w;
  localparam int port_slice_w = num_message_classes * mc_slice_w;
  localparam int flags_w      = num_ports * port_slice_w;

  logic [flags_w-1:0]              flags_q_r;
  logic [port_slice_w-1:0]         port_slice_s;
  logic [mc_slice_w-1:0]           mc_slice_s;
  logic [rc_slice_w-1:0]           vc_flags_s;
  logic [width-1:0]                reduced_s;
  logic [width-1:0]                s2_flags_nxt_s;
  logic                            sel_ok_s;

  logic                            s1_valid_r;
  logic [port_slice_w-1:0]         s1_flags_r;
  logic [num_message_classes-1:0]  s1_mc_r;
  logic [num_resource_classes-1:0] s1_orc_r;
  logic                            s1_err_r;

  logic                            s2_valid_r;
  logic [width-1:0]                s2_flags_r;
  logic                            s2_err_r;

  logic                            s2_adv_s;

  // S2 moves when empty or drained; S1 moves whenever S2 does.
  assign s2_adv_s  = !s2_valid_r | resp_ready;
  assign req_ready = !s1_valid_r | s2_adv_s;

  assign sel_ok_s = is_onehot(64'(req_mc)) & is_onehot(64'(req_op)) &
                    is_onehot(64'(req_orc));

  c_select_1ofn #(.num_ports(num_ports), .width(port_slice_w)) u_sel_port (
    .select   (req_op),
    .data_in  (flags_q_r),
    .data_out (port_slice_s)
  );

  c_select_1ofn #(.num_ports(num_message_classes), .width(mc_slice_w)) u_sel_mc (
    .select   (s1_mc_r),
    .data_in  (s1_flags_r),
    .data_out (mc_slice_s)
  );

  c_select_1ofn #(.num_ports(num_resource_classes), .width(rc_slice_w)) u_sel_rc (
    .select   (s1_orc_r),
    .data_in  (mc_slice_s),
    .data_out (vc_flags_s)
  );

  rtr_flags_reduce #(
    .num_vcs_per_class (num_vcs_per_class),
    .width             (width),
    .reduce_mode       (reduce_mode)
  ) u_reduce (
    .vc_flags (vc_flags_s),
    .reduced  (reduced_s)
  );

  // A malformed select forces an all-zero flag result.
  always_comb begin
    if (s1_err_r) begin
      s2_flags_nxt_s = '0;
    end else begin
      s2_flags_nxt_s = reduced_s;
    end
  end

  // Flag state: clear first, then set, so set wins on the same bit.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      flags_q_r <= '0;
    end else begin
      flags_q_r <= (flags_q_r & ~flags_clr) | flags_set;
    end
  end

  // Stage 1: capture the port slice (pre-update flags) and class selects.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      s1_valid_r <= 1'b0;
      s1_flags_r <= '0;
      s1_mc_r    <= '0;
      s1_orc_r   <= '0;
      s1_err_r   <= 1'b0;
    end else if (req_ready) begin
      s1_valid_r <= req_valid;
      if (req_valid) begin
        s1_flags_r <= port_slice_s;
        s1_mc_r    <= req_mc;
        s1_orc_r   <= req_orc;
        s1_err_r   <= !sel_ok_s;
      end
    end
  end

  // Stage 2: register the reduced result; holds while the consumer stalls.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      s2_valid_r <= 1'b0;
      s2_flags_r <= '0;
      s2_err_r   <= 1'b0;
    end else if (s2_adv_s) begin
      s2_valid_r <= s1_valid_r;
      if (s1_valid_r) begin
        s2_flags_r <= s2_flags_nxt_s;
        s2_err_r   <= s1_err_r;
      end
    end
  end

  assign flags_q    = flags_q_r;
  assign resp_valid = s2_valid_r;
  assign resp_flags = s2_flags_r;
  assign resp_err   = s2_err_r;

endmodule

// File: tb/tb_rtr_flags_mux_pipe.sv
// Bench for rtr_flags_mux_pipe: one default-config instance plus three
// 4-VC instances (FIRST/OR/AND) sharing the request handshake. A
// transaction-level model tracks flag state and in-flight requests.
module tb_rtr_flags_mux_pipe;
  import c_constants::*;

  localparam int FA = 20;   // 5 ports * 2 mc * 2 rc * 1 vc * 1 bit
  localparam int FV = 80;   // 5 ports * 2 mc * 2 rc * 4 vc * 1 bit

  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  logic [FA-1:0] fs_a, fc_a, fq_a;
  logic [FV-1:0] fs_v, fc_v, fq_f, fq_o, fq_n;
  logic          req_valid, resp_ready;
  logic [1:0]    req_mc, req_orc;
  logic [4:0]    req_op;
  logic          rr_a, rr_f, rr_o, rr_n;
  logic          rv_a, rv_f, rv_o, rv_n;
  logic [0:0]    rf_a, rf_f, rf_o, rf_n;
  logic          re_a, re_f, re_o, re_n;

  rtr_flags_mux_pipe dut (
    .clk(clk), .reset(reset), .flags_set(fs_a), .flags_clr(fc_a),
    .req_valid(req_valid), .req_ready(rr_a), .req_mc(req_mc), .req_op(req_op),
    .req_orc(req_orc), .resp_valid(rv_a), .resp_ready(resp_ready),
    .resp_flags(rf_a), .resp_err(re_a), .flags_q(fq_a));

  rtr_flags_mux_pipe #(.num_vcs_per_class(4), .reduce_mode(REDUCE_FIRST)) dut_first (
    .clk(clk), .reset(reset), .flags_set(fs_v), .flags_clr(fc_v),
    .req_valid(req_valid), .req_ready(rr_f), .req_mc(req_mc), .req_op(req_op),
    .req_orc(req_orc), .resp_valid(rv_f), .resp_ready(resp_ready),
    .resp_flags(rf_f), .resp_err(re_f), .flags_q(fq_f));

  rtr_flags_mux_pipe #(.num_vcs_per_class(4), .reduce_mode(REDUCE_OR)) dut_or (
    .clk(clk), .reset(reset), .flags_set(fs_v), .flags_clr(fc_v),
    .req_valid(req_valid), .req_ready(rr_o), .req_mc(req_mc), .req_op(req_op),
    .req_orc(req_orc), .resp_valid(rv_o), .resp_ready(resp_ready),
    .resp_flags(rf_o), .resp_err(re_o), .flags_q(fq_o));

  rtr_flags_mux_pipe #(.num_vcs_per_class(4), .reduce_mode(REDUCE_AND)) dut_and (
    .clk(clk), .reset(reset), .flags_set(fs_v), .flags_clr(fc_v),
    .req_valid(req_valid), .req_ready(rr_n), .req_mc(req_mc), .req_op(req_op),
    .req_orc(req_orc), .resp_valid(rv_n), .resp_ready(resp_ready),
    .resp_flags(rf_n), .resp_err(re_n), .flags_q(fq_n));

  // Reference model state.
  typedef struct {
    int   tag;
    logic fa, ea, ff, fo, fn;
  } txn_t;

  txn_t          q[$];
  logic [FA-1:0] ma;
  logic [FV-1:0] mv;
  int            edge_cnt;
  int            n_checks;
  int            n_fail;
  logic          acc_d;

  task automatic check_val(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Index of the single set bit, or -1 if not exactly one bit is set.
  function automatic int oh_idx(input logic [7:0] v, input int n);
    int hits;
    int pos;
    hits = 0;
    pos  = -1;
    for (int i = 0; i < n; i++) begin
      if (v[i]) begin
        hits++;
        pos = i;
      end
    end
    return (hits == 1) ? pos : -1;
  endfunction

  function automatic logic ref_err(input logic [4:0] op, input logic [1:0] mc, input logic [1:0] orc);
    return (oh_idx({3'b000, op}, 5) < 0) || (oh_idx({6'b0, mc}, 2) < 0) ||
           (oh_idx({6'b0, orc}, 2) < 0);
  endfunction

  // Expected flag: locate the class's VCs in the flat vector and reduce.
  function automatic logic ref_flag(input logic [127:0] st, input int nv, input int mode,
                                    input logic [4:0] op, input logic [1:0] mc, input logic [1:0] orc);
    int   base;
    logic a_or, a_and;
    if (ref_err(op, mc, orc)) return 1'b0;
    base = ((oh_idx({3'b000, op}, 5) * 2 + oh_idx({6'b0, mc}, 2)) * 2 +
            oh_idx({6'b0, orc}, 2)) * nv;
    a_or  = 1'b0;
    a_and = 1'b1;
    for (int v = 0; v < nv; v++) begin
      a_or  = a_or | st[base+v];
      a_and = a_and & st[base+v];
    end
    if (mode == REDUCE_FIRST) return st[base];
    if (mode == REDUCE_AND) return a_and;
    return a_or;
  endfunction

  // One clock cycle: drive, check at negedge, advance model at posedge.
  task automatic step(input logic [FA-1:0] sa, input logic [FA-1:0] ca,
                      input logic [FV-1:0] sv, input logic [FV-1:0] cv,
                      input logic v, input logic [4:0] op, input logic [1:0] mc,
                      input logic [1:0] orc, input logic rdy, output logic acc);
    logic exp_ready, exp_valid, pop;
    txn_t t;
    fs_a = sa; fc_a = ca; fs_v = sv; fc_v = cv;
    req_valid = v; req_op = op; req_mc = mc; req_orc = orc; resp_ready = rdy;
    @(negedge clk);
    exp_ready = (q.size() < 2) || rdy;
    exp_valid = (q.size() > 0) && ((edge_cnt - q[0].tag) >= 2);
    check_val("flags_q_a", fq_a, ma);
    check_val("flags_q_v", {fq_f, fq_o, fq_n}, {mv, mv, mv});
    check_val("req_ready", {rr_a, rr_f, rr_o, rr_n}, {4{exp_ready}});
    check_val("resp_valid", {rv_a, rv_f, rv_o, rv_n}, {4{exp_valid}});
    if (exp_valid) begin
      check_val("resp_a", {re_a, rf_a}, {q[0].ea, q[0].fa});
      check_val("resp_v", {re_f, re_o, re_n, rf_f, rf_o, rf_n},
                {{3{q[0].ea}}, q[0].ff, q[0].fo, q[0].fn});
    end
    acc = v && exp_ready;
    pop = exp_valid && rdy;
    t.tag = edge_cnt;
    t.ea  = ref_err(op, mc, orc);
    t.fa  = ref_flag(128'(ma), 1, REDUCE_OR, op, mc, orc);
    t.ff  = ref_flag(128'(mv), 4, REDUCE_FIRST, op, mc, orc);
    t.fo  = ref_flag(128'(mv), 4, REDUCE_OR, op, mc, orc);
    t.fn  = ref_flag(128'(mv), 4, REDUCE_AND, op, mc, orc);
    @(posedge clk);
    if (pop) void'(q.pop_front());
    if (acc) q.push_back(t);
    ma = (ma & ~ca) | sa;
    mv = (mv & ~cv) | sv;
    edge_cnt++;
    #1;
  endtask

  task automatic idle(input logic rdy);
    step('0, '0, '0, '0, 1'b0, 5'b0, 2'b0, 2'b0, rdy, acc_d);
  endtask

  task automatic req(input logic [4:0] op, input logic [1:0] mc, input logic [1:0] orc);
    step('0, '0, '0, '0, 1'b1, op, mc, orc, 1'b1, acc_d);
  endtask

  // Asynchronous reset between clock edges, with immediate output checks.
  task automatic do_reset();
    req_valid = 1'b0;
    #1 reset = 1'b0;
    #1;
    check_val("rst_resp_valid", {rv_a, rv_f, rv_o, rv_n}, 4'b0000);
    check_val("rst_req_ready", {rr_a, rr_f, rr_o, rr_n}, 4'b1111);
    check_val("rst_resp_data", {rf_a, re_a, rf_f, re_f, rf_o, re_o, rf_n, re_n}, 8'h00);
    check_val("rst_flags_q", {fq_a, fq_f}, '0);
    q.delete();
    ma = '0;
    mv = '0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    reset = 1'b1;
  endtask

  initial begin
    logic          rdy, v, acc, saw_stall;
    logic [4:0]    op;
    logic [1:0]    mc, orc;
    logic [FA-1:0] sa, ca;
    logic [FV-1:0] sv, cv;
    int            n_acc;
    logic [4:0]    bp_op[4];
    logic [1:0]    bp_mc[4];

    n_checks = 0; n_fail = 0; edge_cnt = 0;
    ma = '0; mv = '0;
    fs_a = '0; fc_a = '0; fs_v = '0; fc_v = '0;
    req_valid = 1'b0; req_op = '0; req_mc = '0; req_orc = '0; resp_ready = 1'b1;

    // Reset state at power-up.
    #3;
    check_val("init_resp_valid", {rv_a, rv_f, rv_o, rv_n}, 4'b0000);
    check_val("init_req_ready", {rr_a, rr_f, rr_o, rr_n}, 4'b1111);
    check_val("init_flags_q", fq_a, '0);
    @(posedge clk); #1;
    reset = 1'b1;

    // Basic selection: port 2 / mc 1 / rc 0 -> bit 10.
    step(20'h00400, '0, '0, '0, 1'b0, 5'b0, 2'b0, 2'b0, 1'b1, acc_d);
    req(5'b00100, 2'b10, 2'b01);
    req(5'b00100, 2'b01, 2'b10);
    check_val("sel_hit", {rv_a, rf_a}, 2'b11);
    idle(1'b1);
    check_val("sel_other_class", {rv_a, rf_a}, 2'b10);
    idle(1'b1);

    // Set/clear race on bit 0, with requests in that cycle and the next.
    step(20'h00001, 20'h00001, '0, '0, 1'b1, 5'b00001, 2'b01, 2'b01, 1'b1, acc_d);
    check_val("race_flags_q", fq_a[0], 1'b1);
    req(5'b00001, 2'b01, 2'b01);
    check_val("race_old_value", {rv_a, rf_a}, 2'b10);
    idle(1'b1);
    check_val("race_new_value", {rv_a, rf_a}, 2'b11);
    idle(1'b1);

    // Reduction: VCs 0101 for port 0 / mc 0 / rc 0.
    step('0, '0, 80'h5, '0, 1'b0, 5'b0, 2'b0, 2'b0, 1'b1, acc_d);
    req(5'b00001, 2'b01, 2'b01);
    idle(1'b1);
    check_val("reduce_first_or_and", {rv_f, rf_f, rf_o, rf_n}, 4'b1110);
    idle(1'b1);

    // Backpressure: four requests, consumer stalls in cycles 3..6.
    step(20'hA5C39, '0, 80'h3_0000_F0F0_0000_C3A5, '0, 1'b0, 5'b0, 2'b0, 2'b0, 1'b1, acc_d);
    bp_op = '{5'b00001, 5'b00010, 5'b00100, 5'b01000};
    bp_mc = '{2'b01, 2'b10, 2'b01, 2'b10};
    n_acc = 0;
    saw_stall = 1'b0;
    for (int c = 1; c <= 20; c++) begin
      if ((n_acc == 4) && (q.size() == 0)) break;
      rdy = !((c >= 3) && (c <= 6));
      v = (n_acc < 4);
      step('0, '0, '0, '0, v, bp_op[n_acc % 4], bp_mc[n_acc % 4], 2'b10, rdy, acc);
      if (v && !rr_a) saw_stall = 1'b1;
      if (acc) n_acc++;
    end
    check_val("bp_stall_seen", saw_stall, 1'b1);
    check_val("bp_all_accepted", n_acc, 4);
    check_val("bp_drained", q.size(), 0);

    // Malformed port select, followed by a good request.
    req(5'b00110, 2'b01, 2'b01);
    req(5'b00100, 2'b10, 2'b01);
    check_val("err_response", {rv_a, re_a, rf_a}, 3'b110);
    idle(1'b1);
    check_val("err_then_flow", {rv_a, re_a, rf_a}, 3'b101);
    idle(1'b1);

    // Reset with two requests in flight; nothing stale afterwards.
    req(5'b00100, 2'b10, 2'b01);
    req(5'b00001, 2'b01, 2'b01);
    do_reset();
    for (int i = 0; i < 3; i++) idle(1'b1);
    step('0, '0, '0, '0, 1'b1, 5'b10000, 2'b01, 2'b01, 1'b1, acc);
    check_val("first_accept_after_reset", acc, 1'b1);
    idle(1'b1);
    idle(1'b1);

    // Randomized traffic with a reset in the middle.
    v = 1'b0; op = '0; mc = '0; orc = '0; acc = 1'b1;
    for (int i = 0; i < 400; i++) begin
      if (i == 200) do_reset();
      if (acc || !v || (i == 200)) begin
        v = ($urandom_range(0, 3) != 0);
        if ($urandom_range(0, 7) == 0) op = 5'($urandom);
        else op = 5'b00001 << $urandom_range(0, 4);
        if ($urandom_range(0, 9) == 0) mc = 2'($urandom);
        else mc = 2'b01 << $urandom_range(0, 1);
        if ($urandom_range(0, 9) == 0) orc = 2'($urandom);
        else orc = 2'b01 << $urandom_range(0, 1);
      end
      sa = FA'($urandom & $urandom & $urandom);
      ca = FA'($urandom & $urandom);
      sv = FV'({$urandom & $urandom, $urandom & $urandom, $urandom & $urandom});
      cv = FV'({$urandom & $urandom, $urandom & $urandom, $urandom & $urandom});
      rdy = ($urandom_range(0, 3) != 0);
      step(sa, ca, sv, cv, v, op, mc, orc, rdy, acc);
    end
    for (int i = 0; i < 4; i++) idle(1'b1);
    check_val("final_drained", q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
